// File: rtl/tdm_pkg.sv
// tdm_pkg: shared limits and helpers for the tdm_scan_mux design.
//   CHANNELS_MAX - largest supported channel count
//   DIV_MAX      - largest supported slot period in clock cycles
//   SEL_MAX_W    - slot index width needed for CHANNELS_MAX
//   onehot()     - one-hot code of a slot index, zero for an index >= channels
package tdm_pkg;

  localparam int CHANNELS_MAX = 16;
  localparam int DIV_MAX      = 256;
  localparam int SEL_MAX_W    = $clog2(CHANNELS_MAX);

  function automatic logic [CHANNELS_MAX-1:0] onehot(input logic [SEL_MAX_W-1:0] idx,
                                                     input int channels);
    logic [CHANNELS_MAX-1:0] r;
    r = '0;
    if (int'(idx) < channels) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: prescaler, tick generation and slot counter.
//   clk, rst_n - clock, synchronous active-low reset
//   en         - freezes prescaler and slot when low
//   auto_scan  - 1: slot auto-increments with wrap at CHANNELS-1; 0: slot loads man_sel
//   man_sel    - manual slot index; out-of-range values leave the slot unchanged
//   tick       - one-cycle strobe that ends each slot period (DIV cycles)
//   slot       - current slot index (value before the update that tick causes)
import tdm_pkg::*;

module tdm_slot_ctr #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DIV      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             auto_scan,
  input  logic [SEL_W-1:0] man_sel,
  output logic             tick,
  output logic [SEL_W-1:0] slot
);

  // A one-bit prescaler is kept for DIV=1 so the compare stays uniform;
  // it never leaves zero in that case and tick degenerates to en.
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEL_W-1:0] slot_q, slot_d;

  always_comb begin
    tick   = en && (pre_q == PRE_W'(DIV - 1));
    pre_d  = pre_q;
    slot_d = slot_q;
    if (tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PRE_W'(1);
    end
    if (tick) begin
      if (auto_scan) begin
        // Explicit wrap so non-power-of-two channel counts never reach
        // unused slot codes.
        slot_d = (slot_q == SEL_W'(CHANNELS - 1)) ? '0 : slot_q + SEL_W'(1);
      end else if ({1'b0, man_sel} < (SEL_W + 1)'(CHANNELS)) begin
        slot_d = man_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q  <= '0;
      slot_q <= '0;
    end else begin
      pre_q  <= pre_d;
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_scan_mux.sv
// tdm_scan_mux: time-division scan multiplexer with a demultiplexing receiver.
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - scan enable (freezes prescaler, slot, sample and demux outputs)
//   auto_scan   - 1: automatic slot sequencing; 0: slot taken from man_sel
//   man_sel     - manual slot index
//   din         - parallel channel inputs, synchronous to clk
//   data_out    - serialised bit for the slot tagged by slot_oh (registered)
//   slot_oh     - one-hot slot tag travelling with data_out (registered)
//   q           - per-channel hold registers rebuilt from the stream
//   q_valid     - set once every channel has been written since reset
//   frame_start - present only when TDM_FRAME_MARK_EN is defined; one-cycle
//                 marker that accompanies the slot 0 sample in auto mode
// Stream handshake: there is no back-pressure. A sample is valid in the cycle
// after a tick (v1) and the demux stage always accepts it in that cycle.
import tdm_pkg::*;

module tdm_scan_mux #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DIV      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                auto_scan,
  input  logic [SEL_W-1:0]    man_sel,
  input  logic [CHANNELS-1:0] din,
  output logic                data_out,
  output logic [CHANNELS-1:0] slot_oh,
  output logic [CHANNELS-1:0] q,
`ifdef TDM_FRAME_MARK_EN
  output logic                frame_start,
`endif
  output logic                q_valid
);

  logic             tick;
  logic [SEL_W-1:0] slot;

  tdm_slot_ctr #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .DIV      (DIV)
  ) u_slot_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .auto_scan (auto_scan),
    .man_sel   (man_sel),
    .tick      (tick),
    .slot      (slot)
  );

  logic                    data_out_q, data_out_d;
  logic [CHANNELS-1:0]     slot_oh_q, slot_oh_d;
  logic                    v1_q, v1_d;
  logic [CHANNELS-1:0]     q_q, q_d;
  logic [CHANNELS-1:0]     wr_q, wr_d;
  logic                    q_valid_q, q_valid_d;
  logic [CHANNELS_MAX-1:0] oh_full;
  logic                    unused_oh;

  assign oh_full = onehot(SEL_MAX_W'(slot), CHANNELS);
  // Only the low CHANNELS bits of the full-width code are meaningful.
  assign unused_oh = ^oh_full;

  always_comb begin
    data_out_d = data_out_q;
    slot_oh_d  = slot_oh_q;
    v1_d       = tick;
    q_d        = q_q;
    wr_d       = wr_q;
    q_valid_d  = &wr_q;
    if (tick) begin
      data_out_d = din[slot];
      slot_oh_d  = oh_full[CHANNELS-1:0];
    end
    // v1 only follows a tick, so an en drop still lets the pending write land.
    if (v1_q) begin
      q_d  = (q_q & ~slot_oh_q) | (slot_oh_q & {CHANNELS{data_out_q}});
      wr_d = wr_q | slot_oh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= 1'b0;
      slot_oh_q  <= '0;
      v1_q       <= 1'b0;
      q_q        <= '0;
      wr_q       <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      slot_oh_q  <= slot_oh_d;
      v1_q       <= v1_d;
      q_q        <= q_d;
      wr_q       <= wr_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign slot_oh  = slot_oh_q;
  assign q        = q_q;
  assign q_valid  = q_valid_q;

`ifdef TDM_FRAME_MARK_EN
  logic frame_start_q, frame_start_d;

  always_comb begin
    frame_start_d = tick && auto_scan && (slot == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_start_q <= 1'b0;
    else        frame_start_q <= frame_start_d;
  end

  assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_tdm_scan_mux.sv
// tb_tdm_scan_mux: directed bench for tdm_scan_mux.
//   dut_a: CHANNELS=4, DIV=1 (auto scan, manual tracking, mid-frame reset)
//   dut_b: CHANNELS=5, DIV=3 (prescaler, en freeze, wrap, out-of-range man_sel)
// Inputs are driven at the falling edge, outputs checked at the falling edge.
module tb_tdm_scan_mux;

  logic clk;
  logic rst_n;

  logic       en_a, auto_a;
  logic [1:0] man_sel_a;
  logic [3:0] din_a;
  logic       data_out_a, q_valid_a;
  logic [3:0] slot_oh_a, q_a;

  logic       en_b, auto_b;
  logic [2:0] man_sel_b;
  logic [4:0] din_b;
  logic       data_out_b, q_valid_b;
  logic [4:0] slot_oh_b, q_b;

`ifdef TDM_FRAME_MARK_EN
  logic frame_a, frame_b;
`endif

  int n_checks;
  int n_pass;
  logic [4:0] exp_q[$];

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  tdm_scan_mux #(.CHANNELS(4), .DIV(1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_a),
    .auto_scan   (auto_a),
    .man_sel     (man_sel_a),
    .din         (din_a),
    .data_out    (data_out_a),
    .slot_oh     (slot_oh_a),
    .q           (q_a),
`ifdef TDM_FRAME_MARK_EN
    .frame_start (frame_a),
`endif
    .q_valid     (q_valid_a)
  );

  tdm_scan_mux #(.CHANNELS(5), .DIV(3)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_b),
    .auto_scan   (auto_b),
    .man_sel     (man_sel_b),
    .din         (din_b),
    .data_out    (data_out_b),
    .slot_oh     (slot_oh_b),
    .q           (q_b),
`ifdef TDM_FRAME_MARK_EN
    .frame_start (frame_b),
`endif
    .q_valid     (q_valid_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
  endtask

  // advance one rising edge, land on the following falling edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [4:0] exp;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    en_a = 1'b0; auto_a = 1'b0; man_sel_a = '0; din_a = '0;
    en_b = 1'b0; auto_b = 1'b0; man_sel_b = '0; din_b = '0;
    cyc(2);

    // reset state
    check("rst_a_out", {q_valid_a, q_a, slot_oh_a, data_out_a}, '0);
    check("rst_b_out", {q_valid_b, q_b, slot_oh_b, data_out_b}, '0);

    // auto scan, CHANNELS=4, DIV=1
    rst_n = 1'b1; en_a = 1'b1; auto_a = 1'b1; din_a = 4'b1010;
    exp_q.push_back({4'b0001, 1'b0});
    exp_q.push_back({4'b0010, 1'b1});
    exp_q.push_back({4'b0100, 1'b0});
    exp_q.push_back({4'b1000, 1'b1});
    exp_q.push_back({4'b0001, 1'b0});
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      exp = exp_q.pop_front();
      check("a_auto_oh_do", {slot_oh_a, data_out_a}, exp);
`ifdef TDM_FRAME_MARK_EN
      check("a_frame", frame_a, (k == 1 || k == 5) ? 1 : 0);
`endif
    end
    check("a_q_full", q_a, 4'b1010);
    check("a_qv_late", q_valid_a, 0);
    cyc(1);
    check("a_qv_set", q_valid_a, 1);

    // manual mode on A, man_sel=2
    auto_a = 1'b0; man_sel_a = 2'd2;
    cyc(1);
    check("a_man_oh", {slot_oh_a, data_out_a}, {4'b0100, 1'b0});
    din_a = 4'b0100;
    cyc(1);
    check("a_man_do1", {slot_oh_a, data_out_a}, {4'b0100, 1'b1});
    check("a_man_q0", q_a, 4'b1010);
`ifdef TDM_FRAME_MARK_EN
    check("a_man_frame", frame_a, 0);
`endif
    cyc(1);
    check("a_man_q1", q_a, 4'b1110);
    din_a = 4'b0000;
    cyc(1);
    check("a_man_do0", data_out_a, 0);
    check("a_man_q2", q_a, 4'b1110);
    cyc(1);
    check("a_man_q3", q_a, 4'b1010);

    // prescaler, en freeze and wrap on B (CHANNELS=5, DIV=3)
    en_b = 1'b1; auto_b = 1'b1; din_b = 5'b10110;
    cyc(2);
    check("b_pre_wait", slot_oh_b, 5'b00000);
    cyc(1);
    check("b_s0", {slot_oh_b, data_out_b}, {5'b00001, 1'b0});
`ifdef TDM_FRAME_MARK_EN
    check("b_frame_on", frame_b, 1);
    cyc(1);
    check("b_frame_off", frame_b, 0);
    cyc(1);
`else
    cyc(2);
`endif
    check("b_s0_hold", slot_oh_b, 5'b00001);
    cyc(1);
    check("b_s1", {slot_oh_b, data_out_b}, {5'b00010, 1'b1});
    cyc(1);
    en_b = 1'b0;
    cyc(5);
    check("b_frz_oh", slot_oh_b, 5'b00010);
    check("b_frz_q", q_b, 5'b00010);
    en_b = 1'b1;
    cyc(1);
    check("b_resume", slot_oh_b, 5'b00010);
    cyc(1);
    check("b_s2", {slot_oh_b, data_out_b}, {5'b00100, 1'b1});
    cyc(3);
    check("b_s3", {slot_oh_b, data_out_b}, {5'b01000, 1'b0});
    cyc(3);
    check("b_s4", {slot_oh_b, data_out_b}, {5'b10000, 1'b1});
    cyc(1);
    check("b_q_full", q_b, 5'b10110);
    check("b_qv_late", q_valid_b, 0);
    cyc(1);
    check("b_qv_set", q_valid_b, 1);
    cyc(1);
    check("b_wrap", {slot_oh_b, data_out_b}, {5'b00001, 1'b0});
`ifdef TDM_FRAME_MARK_EN
    check("b_frame_wrap", frame_b, 1);
`endif

    // out-of-range man_sel holds the slot, then a legal one loads
    auto_b = 1'b0; man_sel_b = 3'd6;
    cyc(3);
    check("b_oor_1", {slot_oh_b, data_out_b}, {5'b00010, 1'b1});
    cyc(3);
    check("b_oor_2", slot_oh_b, 5'b00010);
    man_sel_b = 3'd3;
    cyc(3);
    check("b_sel3_pre", slot_oh_b, 5'b00010);
    cyc(3);
    check("b_sel3", {slot_oh_b, data_out_b}, {5'b01000, 1'b0});

    // reset mid-frame on A during slot 2
    auto_a = 1'b1; din_a = 4'b1010;
    cyc(1);
    check("a_pre_rst", {slot_oh_a, data_out_a}, {4'b0100, 1'b0});
    check("a_pre_rst_qv", q_valid_a, 1);
    rst_n = 1'b0;
    cyc(1);
    check("a_rst_mid", {q_valid_a, q_a, slot_oh_a, data_out_a}, '0);
    check("b_rst_mid", {q_valid_b, q_b, slot_oh_b, data_out_b}, '0);
    rst_n = 1'b1;
    cyc(1);
    check("a_restart0", {slot_oh_a, data_out_a}, {4'b0001, 1'b0});
    cyc(1);
    check("a_restart1", {slot_oh_a, data_out_a}, {4'b0010, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_scan_mux.md
# tdm_scan_mux

Parametrised time-division multiplexer/demultiplexer for the FPGA datapath. It scans CHANNELS single-bit inputs in sequence and serialises them onto one data line with a one-hot slot strobe. It decodes the stream back into per-channel hold registers. It adds a programmable slot period, a manual-select mode and a frame-complete flag.

## Interface
- CHANNELS, 4, number of input channels; legal range 2..16, need not be a power of two
- SEL_W, $clog2(CHANNELS), slot index width (derived; do not override)
- DIV, 1, clock cycles per slot; legal range 1..256
- clk  in  1  system clock; all logic is rising-edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  scan enable; when low, the prescaler and slot counter freeze
- auto_scan  in  1  1 = slot auto-increments; 0 = slot loads from man_sel
- man_sel  in  SEL_W  manual slot index, used when auto_scan=0
- din  in  CHANNELS  parallel channel inputs
- data_out  out  1  serialised bit, registered
- slot_oh  out  CHANNELS  one-hot tag of the slot that data_out belongs to, registered
- q  out  CHANNELS  demultiplexed hold registers, one per channel
- q_valid  out  1  high once every channel has been written since reset
- frame_start  out  1  only with TDM_FRAME_MARK_EN; one-cycle frame marker

## Operation
- Prescaler pre counts 0..DIV-1 while en=1. tick = en && (pre == DIV-1). pre wraps to 0 on tick. With DIV=1, tick = en.
- Slot counter slot (SEL_W bits) updates on tick only:
  - auto_scan=1: slot <= (slot == CHANNELS-1) ? 0 : slot+1.
  - auto_scan=0: slot <= man_sel if man_sel < CHANNELS; otherwise slot holds.
- Sample stage: on tick, data_out <= din[slot] and slot_oh <= 1 << slot, using the pre-update slot value.
- Demux stage: pipelined valid v1 <= tick. When v1=1, q[i] <= data_out for the single i where slot_oh[i]=1. All other q bits hold.
- Written mask wr (CHANNELS bits): wr |= slot_oh when v1. q_valid = &wr, registered. wr is cleared only by reset.
- en=0: pre, slot, data_out, slot_oh and q all hold. One in-flight v1 still completes its q write.
- A change of auto_scan or man_sel takes effect at the next tick. There is no partial-slot abort.
- Reset values: pre=0, slot=0, v1=0, data_out=0, slot_oh=0, q=0, wr=0, q_valid=0, frame_start=0.

## Timing
- din is sampled at the rising edge where tick=1 (edge T).
- data_out and slot_oh are valid from T+1. q updates at T+2. q_valid rises at the edge after the last mask bit is set, i.e. T+3 relative to the completing tick.
- Slot period is DIV cycles. A full auto frame is CHANNELS*DIV cycles.
- Wrap-around: the slot after CHANNELS-1 is 0, including non-power-of-two CHANNELS. Slot values >= CHANNELS never occur.
- rst_n low at any edge clears all state at that edge, overriding tick. The first tick after release occurs DIV cycles after the first edge with rst_n=1 and en=1.
- din is treated as synchronous to clk. Asynchronous sources are synchronised upstream.

## Configuration
- TDM_FRAME_MARK_EN defined: frame_start pulses high for exactly one cycle, coincident with data_out/slot_oh for slot 0 when auto_scan=1. It never pulses in manual mode.
- TDM_FRAME_MARK_EN undefined: the frame_start port and its register are absent. All other behaviour is identical.

## Structure
- Shared package tdm_pkg holds the CHANNELS_MAX=16 and DIV_MAX=256 limit constants. It also holds a function onehot(idx, CHANNELS).
- One sub-module, tdm_slot_ctr, contains the prescaler, tick generation and the slot counter with mode select. The top level holds the sample stage, the demux stage and the mask.

## Test plan
- Reset then auto scan: CHANNELS=4, DIV=1, din=4'b1010, en=1. Expect data_out sequence 0,1,0,1 with slot_oh 0001,0010,0100,1000 from cycle 1. Expect q=1010 and q_valid=1 by cycle 6.
- Prescaler: DIV=3. Expect slot_oh to change every 3 cycles. Drop en for 5 cycles mid-slot; outputs freeze and resume with the remaining prescaler count.
- Non-power-of-two: CHANNELS=5. Expect the slot sequence 0..4,0 with no slot 5–7. With TDM_FRAME_MARK_EN, frame_start pulses every 5 cycles.
- Manual mode: auto_scan=0, man_sel=2. Expect slot_oh stuck at 0100 and q[2] tracking din[2] with 2-cycle latency. man_sel=6 (CHANNELS=5): slot holds its previous value.
- Reset mid-frame: assert rst_n=0 for 1 cycle during slot 2. Next cycle all outputs are 0 and q_valid=0. Scanning restarts at slot 0.
